// File: rtl/mak8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mak8_pkg
//  Description : Shared MAK-8 front-end definitions: fetch FSM state type,
//                default reset PC and the opcode length decode used by both
//                the fetch unit and the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mak8_pkg;

   typedef enum logic [1:0] {
      S_ISSUE   = 2'd0,
      S_CAPTURE = 2'd1,
      S_PRESENT = 2'd2
   } fetch_state_t;

   localparam logic [15:0] RESET_PC = 16'h0000;

   // Instruction length in bytes from the opcode's top two bits.
   // The reserved class 2'b11 is treated as a single-byte instruction.
   function automatic logic [1:0] instr_len_f(input logic [7:0] opcode);
      logic [1:0] len;
      case (opcode[7:6])
         2'b00:   len = 2'd1;
         2'b01:   len = 2'd2;
         2'b10:   len = 2'd3;
         default: len = 2'd1;
      endcase
      return len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : MAK-8 instruction fetch. Reads byte-wide instruction memory
//                one byte per two cycles, assembles 1-3 byte instructions and
//                hands them to the decoder over valid/ready. Accepts
//                branch/jump redirects from execute at the highest priority.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n       clock (rising edge), asynchronous active-low reset
//    mem_rd_en        read strobe to instruction memory
//    mem_addr         read address (the current fetch pointer)
//    mem_rdata        read data, valid the cycle after mem_rd_en
//    redirect_valid   taken branch/jump
//    redirect_pc      branch/jump target
//    instr_valid      assembled instruction available
//    instr_ready      decoder accepts the instruction
//    instr_opcode     byte 0
//    instr_operand    {byte2, byte1}, unused bytes read as 0
//    instr_len        1, 2 or 3
//    instr_pc         address of the opcode byte
//    next_pc          instr_pc + instr_len (mod 2^16)
//    fetch_pc         current fetch pointer
// ============================================================================
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = mak8_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        instr_opcode,
   output logic [15:0]       instr_operand,
   output logic [1:0]        instr_len,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic [ADDR_W-1:0] fetch_pc
);

   import mak8_pkg::*;

   localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [1:0]        r_idx;
   logic [7:0]        r_opcode;
   logic [7:0]        r_byte1;
   logic [7:0]        r_byte2;
   logic [1:0]        r_len;
   logic [ADDR_W-1:0] r_instr_pc;
   logic [ADDR_W-1:0] r_next_pc;

   logic [1:0]        w_cur_len;
   logic [ADDR_W-1:0] w_len_ext;
   logic              w_more;

   // While the opcode byte is being captured the latched length is stale,
   // so the length comes straight from the returning byte.
   assign w_cur_len = (r_idx == 2'd0) ? instr_len_f(mem_rdata) : r_len;
   assign w_len_ext = {{(ADDR_W-2){1'b0}}, w_cur_len};
   assign w_more    = ({1'b0, r_idx} + 3'd1) < {1'b0, w_cur_len};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_ISSUE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_state_nxt = S_ISSUE;
      end else begin
         case (r_state)
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = w_more ? S_ISSUE : S_PRESENT;
            S_PRESENT: w_state_nxt = instr_ready ? S_ISSUE : S_PRESENT;
            default:   w_state_nxt = S_ISSUE;
         endcase
      end
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_idx      <= 2'd0;
         r_opcode   <= 8'h00;
         r_byte1    <= 8'h00;
         r_byte2    <= 8'h00;
         r_len      <= 2'd1;
         r_instr_pc <= '0;
         r_next_pc  <= RESET_PC + c_pc_one;
      end else if (redirect_valid) begin
         // Any byte returning this cycle is dropped; the pointer is not bumped.
         r_fetch_pc <= redirect_pc;
         r_idx      <= 2'd0;
      end else begin
         case (r_state)
            S_CAPTURE: begin
               r_fetch_pc <= r_fetch_pc + c_pc_one;
               case (r_idx)
                  2'd0: begin
                     r_opcode   <= mem_rdata;
                     r_byte1    <= 8'h00;
                     r_byte2    <= 8'h00;
                     r_len      <= w_cur_len;
                     r_instr_pc <= r_fetch_pc;
                     r_next_pc  <= r_fetch_pc + w_len_ext;
                  end
                  2'd1:    r_byte1 <= mem_rdata;
                  default: r_byte2 <= mem_rdata;
               endcase
               if (w_more) begin
                  r_idx <= r_idx + 2'd1;
               end
            end
            S_PRESENT: begin
               if (instr_ready) begin
                  r_idx <= 2'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   // The FSM rests in S_ISSUE during reset; gating with rst_n keeps the read
   // strobe quiet until reset is released.
   assign mem_rd_en     = rst_n && (r_state == S_ISSUE);
   assign mem_addr      = r_fetch_pc;
   assign fetch_pc      = r_fetch_pc;
   assign instr_valid   = (r_state == S_PRESENT);
   assign instr_opcode  = r_opcode;
   assign instr_operand = {r_byte2, r_byte1};
   assign instr_len     = r_len;
   assign instr_pc      = r_instr_pc;
   assign next_pc       = r_next_pc;

endmodule
`default_nettype wire
